// File: rtl/frame_stats.sv
// frame_stats: per-frame min/max/sum/count of qualifying pixels over a COLS x ROWS raster
module frame_stats #(
    parameter int ADC_W       = 14,
    parameter int COLS        = 384,
    parameter int ROWS        = 288,
    parameter bit IGNORE_ZERO = 1'b1,
    parameter int SUM_W       = ADC_W + 17,
    parameter int CNT_W       = 17
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             FRAME_START,
    input  logic             PIX_VALID,
    input  logic [ADC_W-1:0] IN_ADC,
    output logic [ADC_W-1:0] MIN_OUT,
    output logic [ADC_W-1:0] MAX_OUT,
    output logic [SUM_W-1:0] SUM_OUT,
    output logic [CNT_W-1:0] CNT_OUT,
    output logic             STATS_VALID,
    output logic             BUSY,
    output logic             FRAME_ERR
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_nx;
    logic init, take, qual, col_wrap, last_px;
    logic [CW-1:0] col, col_b, col_nx;
    logic [RW-1:0] row, row_b, row_nx;
    logic [ADC_W-1:0] acc_min, min_b, min_nx, acc_max, max_b, max_nx;
    logic [SUM_W-1:0] acc_sum, sum_b, sum_nx;
    logic [CNT_W-1:0] acc_cnt, cnt_b, cnt_nx;
    always_comb begin
        init     = ENABLE && FRAME_START;
        take     = ENABLE && PIX_VALID && (state == ACTIVE || (state == IDLE && FRAME_START));
        qual     = take && (!IGNORE_ZERO || IN_ADC != '0);
        col_b    = init ? '0 : col;
        row_b    = init ? '0 : row;
        min_b    = init ? '1 : acc_min;
        max_b    = init ? '0 : acc_max;
        sum_b    = init ? '0 : acc_sum;
        cnt_b    = init ? '0 : acc_cnt;
        col_wrap = col_b == CW'(COLS - 1);
        last_px  = take && col_wrap && row_b == RW'(ROWS - 1);
        col_nx   = !take ? col_b : col_wrap ? '0 : col_b + CW'(1);
        row_nx   = take && col_wrap ? row_b + RW'(1) : row_b;
        min_nx   = qual && IN_ADC < min_b ? IN_ADC : min_b;
        max_nx   = qual && IN_ADC > max_b ? IN_ADC : max_b;
        sum_nx   = qual ? sum_b + SUM_W'(IN_ADC) : sum_b;
        cnt_nx   = qual ? cnt_b + CNT_W'(1) : cnt_b;
        state_nx = !ENABLE ? IDLE : last_px ? DONE : (init || state == ACTIVE) ? ACTIVE : IDLE;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            acc_min     <= '0;
            acc_max     <= '0;
            acc_sum     <= '0;
            acc_cnt     <= '0;
            MIN_OUT     <= '0;
            MAX_OUT     <= '0;
            SUM_OUT     <= '0;
            CNT_OUT     <= '0;
            STATS_VALID <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            row         <= row_nx;
            acc_min     <= min_nx;
            acc_max     <= max_nx;
            acc_sum     <= sum_nx;
            acc_cnt     <= cnt_nx;
            BUSY        <= state_nx == ACTIVE;
            STATS_VALID <= state_nx == DONE;
            FRAME_ERR   <= !ENABLE ? 1'b0 : (init && state == ACTIVE) ? 1'b1 : FRAME_ERR;
            // results land with the pulse; an empty frame reports zero, not the all-ones seed
            if (state_nx == DONE) begin
                MIN_OUT <= cnt_nx == '0 ? '0 : min_nx;
                MAX_OUT <= max_nx;
                SUM_OUT <= sum_nx;
                CNT_OUT <= cnt_nx;
            end
        end
    end
endmodule
